// File: rtl/stable_monitor_pkg.sv
// +-----------------------------------------------------------------+
// | stable_monitor_pkg : shared types and helpers for stable_monitor |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package stable_monitor_pkg;

  typedef enum logic [1:0] {
    STABLE  = 2'd0,
    CHANGED = 2'd1,
    ROSE    = 2'd2,
    FELL    = 2'd3
  } mode_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] count, input logic [31:0] max);
    return (count >= max) ? count : count + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stable_monitor_chan.sv
// +-----------------------------------------------------------------+
// | stable_monitor_chan : one channel's compare, pulses and counters |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module stable_monitor_chan #(
  parameter int W     = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     sig,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic             clr,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_raw
);
  import stable_monitor_pkg::*;

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [W-1:0]     prev_q, prev_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             match;
  logic             pass_raw;

  always_comb begin
    match = 1'b0;
    case (mode_e'(mode))
      STABLE:  match = (sig == prev_q);
      CHANGED: match = (sig != prev_q);
      ROSE:    match = ~prev_q[0] & sig[0];
      FELL:    match = prev_q[0] & ~sig[0];
      default: match = 1'b0;
    endcase
  end

  assign pass_raw = en & match;
  assign fail_raw = en & ~match;

  // prev tracks sig unconditionally so a re-enabled channel never sees a stale value
  always_comb begin
    prev_d     = sig;
    pass_d     = pass_raw;
    fail_d     = fail_raw;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (clr) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else begin
      if (pass_raw) pass_cnt_d = CNT_W'(sat_inc(32'(pass_cnt_q), CNT_MAX));
      if (fail_raw) fail_cnt_d = CNT_W'(sat_inc(32'(fail_cnt_q), CNT_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q     <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      prev_q     <= prev_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pass     = pass_q;
  assign fail     = fail_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;

endmodule

`default_nettype wire

// File: rtl/stable_monitor.sv
// +-----------------------------------------------------------------+
// | stable_monitor : multi-channel stable/changed/rose/fell checker  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module stable_monitor #(
  parameter  int N_CH  = 4,
  parameter  int W     = 1,
  parameter  int CNT_W = 8,
  parameter  int TS_W  = 16,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*W-1:0]     sig,
  input  logic [N_CH*2-1:0]     mode,
  input  logic [N_CH-1:0]       en,
  input  logic                  clr,
  output logic [N_CH-1:0]       pass,
  output logic [N_CH-1:0]       fail,
  output logic [N_CH*CNT_W-1:0] pass_cnt,
  output logic [N_CH*CNT_W-1:0] fail_cnt,
  output logic                  err_sticky,
  output logic [CH_W-1:0]       first_fail_ch,
  output logic [TS_W-1:0]       first_fail_ts
);
  import stable_monitor_pkg::*;

  logic [N_CH-1:0] fail_raw;
  logic [TS_W-1:0] stamp_q, stamp_d;
  logic            err_sticky_q, err_sticky_d;
  logic [CH_W-1:0] first_fail_ch_q, first_fail_ch_d;
  logic [TS_W-1:0] first_fail_ts_q, first_fail_ts_d;
  logic [CH_W-1:0] low_ch;
  logic            any_fail;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    stable_monitor_chan #(
      .W     (W),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .sig      (sig[i*W +: W]),
      .mode     (mode[i*2 +: 2]),
      .en       (en[i]),
      .clr      (clr),
      .pass     (pass[i]),
      .fail     (fail[i]),
      .pass_cnt (pass_cnt[i*CNT_W +: CNT_W]),
      .fail_cnt (fail_cnt[i*CNT_W +: CNT_W]),
      .fail_raw (fail_raw[i])
    );
  end

  // Descending scan so the lowest failing index wins
  always_comb begin
    low_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (fail_raw[i]) low_ch = CH_W'(i);
    end
  end

  assign any_fail = |fail_raw;

  always_comb begin
    stamp_d         = stamp_q + TS_W'(1);
    err_sticky_d    = err_sticky_q;
    first_fail_ch_d = first_fail_ch_q;
    first_fail_ts_d = first_fail_ts_q;
    if (clr) begin
      err_sticky_d    = 1'b0;
      first_fail_ch_d = '0;
      first_fail_ts_d = '0;
    end else if (any_fail && !err_sticky_q) begin
      err_sticky_d    = 1'b1;
      first_fail_ch_d = low_ch;
      first_fail_ts_d = stamp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stamp_q         <= '0;
      err_sticky_q    <= 1'b0;
      first_fail_ch_q <= '0;
      first_fail_ts_q <= '0;
    end else begin
      stamp_q         <= stamp_d;
      err_sticky_q    <= err_sticky_d;
      first_fail_ch_q <= first_fail_ch_d;
      first_fail_ts_q <= first_fail_ts_d;
    end
  end

  assign err_sticky    = err_sticky_q;
  assign first_fail_ch = first_fail_ch_q;
  assign first_fail_ts = first_fail_ts_q;

endmodule

`default_nettype wire

// File: tb/tb_stable_monitor.sv
// +-----------------------------------------------------------------+
// | tb_stable_monitor : scoreboard bench for stable_monitor          |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_stable_monitor;

  localparam int N_CH  = 4;
  localparam int W     = 1;
  localparam int CNT_W = 3;
  localparam int TS_W  = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       sig;
  logic [7:0]       mode;
  logic [3:0]       en;
  logic             clr;
  logic [3:0]       pass;
  logic [3:0]       fail;
  logic [11:0]      pass_cnt;
  logic [11:0]      fail_cnt;
  logic             err_sticky;
  logic [1:0]       first_fail_ch;
  logic [15:0]      first_fail_ts;

  typedef struct packed {
    logic [3:0] pass;
    logic [3:0] fail;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       x;
  logic [3:0] mdl_prev;
  int         n_checks = 0;
  int         n_fail   = 0;

  stable_monitor #(
    .N_CH  (N_CH),
    .W     (W),
    .CNT_W (CNT_W),
    .TS_W  (TS_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sig           (sig),
    .mode          (mode),
    .en            (en),
    .clr           (clr),
    .pass          (pass),
    .fail          (fail),
    .pass_cnt      (pass_cnt),
    .fail_cnt      (fail_cnt),
    .err_sticky    (err_sticky),
    .first_fail_ch (first_fail_ch),
    .first_fail_ts (first_fail_ts)
  );

  always #5 clk = ~clk;

  function automatic logic exp_ok(input logic [1:0] m, input logic c, input logic p);
    case (m)
      2'd0:    return c == p;
      2'd1:    return c != p;
      2'd2:    return !p && c;
      default: return p && !c;
    endcase
  endfunction

  // Drive one cycle, push the reference pulses, and advance past the edge
  task automatic step(input logic r, input logic [3:0] s, input logic [3:0] e,
                      input logic [7:0] m, input logic c);
    exp_t y;
    rst_n = r; sig = s; en = e; mode = m; clr = c;
    y = '0;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        if (e[i]) begin
          if (exp_ok(m[2*i +: 2], s[i], mdl_prev[i])) y.pass[i] = 1'b1;
          else y.fail[i] = 1'b1;
        end
      end
    end
    mdl_prev = r ? s : 4'b0;
    sb_q.push_back(y);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 4'b0, 4'b0, 8'h00, 1'b0);
    sb_q.delete();
  endtask

  task automatic test_reset();
    step(1'b0, 4'b0, 4'b0, 8'h00, 1'b0);
    step(1'b0, 4'b1111, 4'b1111, 8'hff, 1'b0);
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      n_checks++;
      if ({pass, fail} !== x) begin
        n_fail++;
        $display("FAIL reset_pulses got %b want %b", {pass, fail}, x);
      end
    end
    n_checks++;
    if ({pass_cnt, fail_cnt, err_sticky, first_fail_ch, first_fail_ts} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got cnt=%h/%h sticky=%b ch=%0d ts=%0d want all 0",
               pass_cnt, fail_cnt, err_sticky, first_fail_ch, first_fail_ts);
    end
  endtask

  task automatic test_stable();
    logic [9:0] seq = 10'b0000011010;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, {3'b0, seq[k]}, 4'b0001, 8'h00, 1'b0);
      x = sb_q.pop_front();
      n_checks++;
      if ({pass, fail} !== x) begin
        n_fail++;
        $display("FAIL stable_c%0d got %b want %b", k, {pass, fail}, x);
      end
    end
    n_checks++;
    if (pass_cnt[2:0] !== 3'd6 || fail_cnt[2:0] !== 3'd4) begin
      n_fail++;
      $display("FAIL stable_counts got p=%0d f=%0d want p=6 f=4", pass_cnt[2:0], fail_cnt[2:0]);
    end
    n_checks++;
    if (err_sticky !== 1'b1 || first_fail_ch !== 2'd0 || first_fail_ts !== 16'd1) begin
      n_fail++;
      $display("FAIL stable_first got sticky=%b ch=%0d ts=%0d want 1/0/1",
               err_sticky, first_fail_ch, first_fail_ts);
    end
  endtask

  task automatic test_rose_fell();
    logic [9:0] seq = 10'b0000011010;
    logic [9:0] ch1_pass = '0;
    logic [9:0] ch2_pass = '0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, {1'b0, seq[k], seq[k], 1'b0}, 4'b0110, 8'b00_11_10_00, 1'b0);
      x = sb_q.pop_front();
      ch1_pass[k] = pass[1];
      ch2_pass[k] = pass[2];
      n_checks++;
      if ({pass, fail} !== x) begin
        n_fail++;
        $display("FAIL rosefell_c%0d got %b want %b", k, {pass, fail}, x);
      end
    end
    n_checks++;
    if (ch1_pass !== 10'b0000001010 || ch2_pass !== 10'b0000100100) begin
      n_fail++;
      $display("FAIL rosefell_pattern got rose=%b fell=%b want 0000001010/0000100100",
               ch1_pass, ch2_pass);
    end
    n_checks++;
    if (pass_cnt[5:3] !== 3'd2 || pass_cnt[8:6] !== 3'd2 ||
        fail_cnt[5:3] !== 3'd7 || fail_cnt[8:6] !== 3'd7) begin
      n_fail++;
      $display("FAIL rosefell_counts got p1=%0d p2=%0d f1=%0d f2=%0d want 2/2/7/7",
               pass_cnt[5:3], pass_cnt[8:6], fail_cnt[5:3], fail_cnt[8:6]);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    step(1'b1, 4'b0000, 4'b1010, 8'h00, 1'b0);
    step(1'b1, 4'b1010, 4'b1010, 8'h00, 1'b0);
    step(1'b1, 4'b0010, 4'b1010, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      // outputs of the last step are what is visible now; only compare the final pop
      x = sb_q.pop_front();
    end
    n_checks++;
    if ({pass, fail} !== x) begin
      n_fail++;
      $display("FAIL same_pulses got %b want %b", {pass, fail}, x);
    end
    n_checks++;
    if (err_sticky !== 1'b1 || first_fail_ch !== 2'd1 || first_fail_ts !== 16'd1) begin
      n_fail++;
      $display("FAIL same_first got sticky=%b ch=%0d ts=%0d want 1/1/1",
               err_sticky, first_fail_ch, first_fail_ts);
    end
    do_reset();
    step(1'b1, 4'b0000, 4'b1010, 8'h00, 1'b0);
    x = sb_q.pop_front();
    n_checks++;
    if (err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL same_pre got sticky=%b want 0", err_sticky);
    end
    step(1'b1, 4'b1010, 4'b1010, 8'h00, 1'b0);
    x = sb_q.pop_front();
    n_checks++;
    if (fail !== 4'b1010 || err_sticky !== 1'b1 || first_fail_ch !== 2'd1) begin
      n_fail++;
      $display("FAIL same_edge got fail=%b sticky=%b ch=%0d want 1010/1/1",
               fail, err_sticky, first_fail_ch);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 4'b0000, 4'b0001, 8'h00, 1'b0);
      x = sb_q.pop_front();
      n_checks++;
      if ({pass, fail} !== x) begin
        n_fail++;
        $display("FAIL sat_c%0d got %b want %b", k, {pass, fail}, x);
      end
    end
    n_checks++;
    if (pass_cnt[2:0] !== 3'd7) begin
      n_fail++;
      $display("FAIL sat_pass got %0d want 7", pass_cnt[2:0]);
    end
    step(1'b1, 4'b0001, 4'b0001, 8'h00, 1'b0);
    x = sb_q.pop_front();
    n_checks++;
    if (fail_cnt[2:0] !== 3'd1 || err_sticky !== 1'b1 || first_fail_ts !== 16'd12) begin
      n_fail++;
      $display("FAIL sat_fail got f=%0d sticky=%b ts=%0d want 1/1/12",
               fail_cnt[2:0], err_sticky, first_fail_ts);
    end
    step(1'b1, 4'b0000, 4'b0001, 8'h00, 1'b1);
    x = sb_q.pop_front();
    n_checks++;
    if ({pass, fail} !== x || fail_cnt[2:0] !== 3'd0 || pass_cnt[2:0] !== 3'd0 ||
        err_sticky !== 1'b0 || first_fail_ts !== 16'd0) begin
      n_fail++;
      $display("FAIL clr_fail got pf=%b f=%0d p=%0d sticky=%b ts=%0d want pf=%b 0/0/0/0",
               {pass, fail}, fail_cnt[2:0], pass_cnt[2:0], err_sticky, first_fail_ts, x);
    end
    step(1'b1, 4'b0000, 4'b0001, 8'h00, 1'b0);
    x = sb_q.pop_front();
    n_checks++;
    if ({pass, fail} !== x || pass_cnt[2:0] !== 3'd1 || err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_after got pf=%b p=%0d sticky=%b want pf=%b 1/0",
               {pass, fail}, pass_cnt[2:0], err_sticky, x);
    end
  endtask

  task automatic test_enable();
    logic [2:0] off_seq = 3'b101;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 4'b0000, 4'b0001, 8'h00, 1'b0);
      x = sb_q.pop_front();
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, {3'b0, off_seq[k]}, 4'b0000, 8'h00, 1'b0);
      x = sb_q.pop_front();
      n_checks++;
      if ({pass, fail} !== x || pass_cnt[2:0] !== 3'd2 || fail_cnt[2:0] !== 3'd0) begin
        n_fail++;
        $display("FAIL en_off_c%0d got pf=%b p=%0d f=%0d want pf=%b 2/0",
                 k, {pass, fail}, pass_cnt[2:0], fail_cnt[2:0], x);
      end
    end
    step(1'b1, 4'b0001, 4'b0001, 8'h00, 1'b0);
    x = sb_q.pop_front();
    n_checks++;
    if (pass !== 4'b0001 || fail !== 4'b0000 || pass_cnt[2:0] !== 3'd3) begin
      n_fail++;
      $display("FAIL en_back got pass=%b fail=%b p=%0d want 0001/0000/3",
               pass, fail, pass_cnt[2:0]);
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 4'b0001, 4'b0001, 8'h00, 1'b0);
    x = sb_q.pop_front();
    step(1'b0, 4'b0001, 4'b0001, 8'h00, 1'b0);
    x = sb_q.pop_front();
    n_checks++;
    if ({pass, fail, pass_cnt, fail_cnt, err_sticky, first_fail_ch, first_fail_ts} !== '0) begin
      n_fail++;
      $display("FAIL midrst_state got pf=%b cnt=%h/%h sticky=%b ch=%0d ts=%0d want all 0",
               {pass, fail}, pass_cnt, fail_cnt, err_sticky, first_fail_ch, first_fail_ts);
    end
    step(1'b1, 4'b0001, 4'b0001, 8'h00, 1'b0);
    x = sb_q.pop_front();
    n_checks++;
    if ({pass, fail} !== x || fail !== 4'b0001 || fail_cnt[2:0] !== 3'd1 ||
        err_sticky !== 1'b1 || first_fail_ts !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_first got pf=%b f=%0d sticky=%b ts=%0d want pf=%b 1/1/0",
               {pass, fail}, fail_cnt[2:0], err_sticky, first_fail_ts, x);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    sig      = '0;
    mode     = '0;
    en       = '0;
    clr      = 1'b0;
    mdl_prev = '0;
    test_reset();
    test_stable();
    test_rose_fell();
    test_same_cycle();
    test_saturation();
    test_enable();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
